// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: one SRAM access channel (request side plus read return).
//
// Handshake: an access transfers on every rising clock edge where req && ready
// are both high. While req is high the requester holds addr, write_enable and
// write_data stable. The requester may drop req before acceptance, in which
// case no access is issued. ready may be high while req is low; it carries no
// meaning on its own. read_valid is a one-cycle strobe qualifying read_data.
//
// Signals:
//   req          requester -> responder  access request
//   ready        responder -> requester  access accepted this cycle (with req)
//   addr         requester -> responder  access address
//   write_enable requester -> responder  1 = write, 0 = read
//   write_data   requester -> responder  write payload
//   read_data    responder -> requester  read payload
//   read_valid   responder -> requester  read_data valid this cycle
//
// Modports:
//   master  drives the request (used by the arbiter toward the controller)
//   slave   answers the request (used by the arbiter toward each requester)
interface sram_arbiter_if #(
    parameter int ADDR_BITS = 20,
    parameter int DATA_BITS = 16
);
    logic                 req;
    logic                 ready;
    logic [ADDR_BITS-1:0] addr;
    logic                 write_enable;
    logic [DATA_BITS-1:0] write_data;
    logic [DATA_BITS-1:0] read_data;
    logic                 read_valid;

    // The controller returns no read strobe; the arbiter regenerates it from
    // its own tag pipe, so the master view carries no read_valid.
    modport master (
        output req, addr, write_enable, write_data,
        input  ready, read_data
    );

    modport slave (
        input  req, addr, write_enable, write_data,
        output ready, read_data, read_valid
    );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter in front of one sram_controller.
//
// Each port keeps the grant for up to BURST_MAX accepted accesses, then the
// grant rotates if the other port is waiting. Reads are tagged with the
// issuing port in a READ_LATENCY-deep pipe so returning data reaches the
// originating port even after the grant has moved on.
//
// Ports:
//   clk    in   single clock, rising edge
//   reset  in   synchronous, active-high
//   s0     slave  requester port 0
//   s1     slave  requester port 1
//   m      master controller side
//   grant  out  one-hot current owner (00 none, 01 port 0, 10 port 1)
module sram_arbiter #(
    parameter int ADDR_BITS    = 20,
    parameter int DATA_BITS    = 16,
    parameter int BURST_MAX    = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    sram_arbiter_if.slave        s0,
    sram_arbiter_if.slave        s1,
    sram_arbiter_if.master       m,
    output logic [1:0]           grant
);

    localparam int BEAT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

    // Encoding matches the one-hot grant debug output.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT0 = 2'b01,
        ST_GRANT1 = 2'b10
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_last;
    logic [BEAT_W-1:0]       r_beat;
    logic [BEAT_W-1:0]       w_next_beat;
    logic [READ_LATENCY-1:0] r_tag_v;
    logic [READ_LATENCY-1:0] r_tag_p;

    logic                    w_in_grant;
    logic                    w_owner;
    logic                    w_own_req;
    logic [ADDR_BITS-1:0]    w_own_addr;
    logic                    w_own_we;
    logic [DATA_BITS-1:0]    w_own_wd;
    logic                    w_other_req;
    logic                    w_accept;
    logic                    w_release;

    // Mux of the owning port's request; all zero when nobody holds the grant.
    always_comb begin
        w_in_grant  = 1'b0;
        w_owner     = 1'b0;
        w_own_req   = 1'b0;
        w_own_addr  = '0;
        w_own_we    = 1'b0;
        w_own_wd    = '0;
        w_other_req = 1'b0;
        case (r_state)
            ST_GRANT0: begin
                w_in_grant  = 1'b1;
                w_owner     = 1'b0;
                w_own_req   = s0.req;
                w_own_addr  = s0.addr;
                w_own_we    = s0.write_enable;
                w_own_wd    = s0.write_data;
                w_other_req = s1.req;
            end
            ST_GRANT1: begin
                w_in_grant  = 1'b1;
                w_owner     = 1'b1;
                w_own_req   = s1.req;
                w_own_addr  = s1.addr;
                w_own_we    = s1.write_enable;
                w_own_wd    = s1.write_data;
                w_other_req = s0.req;
            end
            default: ;
        endcase
    end

    assign w_accept  = w_in_grant && w_own_req && m.ready;
    // Grant ends when the owner lets go, or on the burst's final acceptance.
    assign w_release = w_in_grant && (!w_own_req || (w_accept && (r_beat == BEAT_LAST)));

    always_comb begin
        w_next_state = r_state;
        w_next_beat  = r_beat;
        if (r_state == ST_IDLE) begin
            if (s0.req && s1.req) begin
                // Tie goes to the port that was not granted most recently.
                w_next_state = r_last ? ST_GRANT0 : ST_GRANT1;
            end else if (s0.req) begin
                w_next_state = ST_GRANT0;
            end else if (s1.req) begin
                w_next_state = ST_GRANT1;
            end
        end else if (w_release) begin
            if (w_other_req) begin
                w_next_state = w_owner ? ST_GRANT0 : ST_GRANT1;
            end else if (w_own_req) begin
                // Burst expired but nobody else wants the bus: fresh burst.
                w_next_state = r_state;
            end else begin
                w_next_state = ST_IDLE;
            end
            w_next_beat = '0;
        end else if (w_accept) begin
            w_next_beat = r_beat + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_beat  <= '0;
        end else begin
            r_state <= w_next_state;
            r_beat  <= w_next_beat;
            if (w_next_state == ST_GRANT0) begin
                r_last <= 1'b0;
            end else if (w_next_state == ST_GRANT1) begin
                r_last <= 1'b1;
            end
        end
    end

    // Read tag pipe: stage i holds reads accepted i+1 cycles ago.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag_v <= '0;
            r_tag_p <= '0;
        end else begin
            r_tag_v[0] <= w_accept && !w_own_we;
            r_tag_p[0] <= w_owner;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_p[i] <= r_tag_p[i-1];
            end
        end
    end

    assign m.req          = w_in_grant && w_own_req;
    assign m.addr         = w_own_addr;
    assign m.write_enable = w_own_we;
    assign m.write_data   = w_own_wd;

    assign s0.ready      = (r_state == ST_GRANT0) && m.ready;
    assign s1.ready      = (r_state == ST_GRANT1) && m.ready;
    assign s0.read_data  = m.read_data;
    assign s1.read_data  = m.read_data;
    assign s0.read_valid = r_tag_v[READ_LATENCY-1] && !r_tag_p[READ_LATENCY-1];
    assign s1.read_valid = r_tag_v[READ_LATENCY-1] &&  r_tag_p[READ_LATENCY-1];

    assign grant = {r_state == ST_GRANT1, r_state == ST_GRANT0};

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port round-robin arbiter that shares one `sram_controller` request interface between two independent requesters, e.g. a pattern tester and a display/readback engine. It sits directly upstream of `sram_controller`, drives the controller's `req`/`addr`/`write_enable`/`write_data`, and routes the controller's `read_data` back with a per-port valid strobe. Grants are held for bursts of up to `BURST_MAX` accepted accesses to keep SRAM turnarounds low, while round-robin rotation guarantees fairness.

## Interface
- `ADDR_BITS`, 20, SRAM address width
- `DATA_BITS`, 16, SRAM data width
- `BURST_MAX`, 8, max accepted accesses per grant before forced rotation (>=1)
- `READ_LATENCY`, 2, cycles from controller acceptance (`m_req && m_ready`) of a read to valid `m_read_data` (>=1)
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: synchronous, active-high
- `s0_req`, `s1_req` in 1: port request; holds addr/we/wdata stable while high
- `s0_ready`, `s1_ready` out 1: access accepted this cycle when `sN_req && sN_ready`
- `s0_addr`, `s1_addr` in ADDR_BITS: access address
- `s0_write_enable`, `s1_write_enable` in 1: 1 = write, 0 = read
- `s0_write_data`, `s1_write_data` in DATA_BITS: write data
- `s0_read_data`, `s1_read_data` out DATA_BITS: both wired to `m_read_data`
- `s0_read_valid`, `s1_read_valid` out 1: one-cycle strobe, read data valid for this port
- `grant` out 2: one-hot current owner (00 = none), debug
- `m_req` out 1, `m_ready` in 1, `m_addr` out ADDR_BITS, `m_write_enable` out 1, `m_write_data` out DATA_BITS, `m_read_data` in DATA_BITS: controller side

## Operation
- States: IDLE, GRANT0, GRANT1. Registered state; `last` register holds the most recently granted port (reset 1, so port 0 wins first).
- IDLE: no request -> stay. Exactly one request -> GRANTn for that port. Both -> GRANT for port != `last`.
- GRANTn: `m_req = sN_req`, `m_addr`/`m_write_enable`/`m_write_data` = port n inputs, `sN_ready = m_ready`, other port's ready = 0. `beat` counter increments on each accepted access.
- Release when `sN_req` low, or when an access is accepted with `beat == BURST_MAX-1`. On release: other port requesting -> GRANT other; else own port still requesting (burst expiry only) -> GRANTn again with `beat` = 0; else IDLE. `beat` clears on every grant change; `last` updates to n.
- Outside GRANTn: `m_req = 0`, `m_write_enable = 0`, `m_addr`/`m_write_data` = 0, both readys 0.
- Read tagging: READ_LATENCY-stage shift pipe of {valid, port}; stage 0 loaded with (accepted && !we, owner). Pipe output drives `sN_read_valid`. Reads issued before a grant change still return to their originating port.
- Writes produce no `read_valid`.

## Timing
- Reset values: state IDLE, `grant` 00, `last` = 1, `beat` 0, all readys 0, `m_req` 0, `m_write_enable` 0, `m_addr` 0, `m_write_data` 0, both `read_valid` 0, tag pipe cleared.
- Arbitration latency: a request seen in IDLE at cycle t gets grant at t+1; earliest acceptance t+1.
- Direct handoff GRANT0 -> GRANT1 costs one cycle with `m_req` low only if the new owner's req is deasserted; otherwise the new owner can be accepted the cycle after release.
- Read data: accepted read at cycle t -> `sN_read_valid` high at t+READ_LATENCY exactly, for one cycle.
- Back-to-back reads: one `read_valid` per accepted read, order preserved.
- Reset mid-operation: in-flight reads dropped, no `read_valid` after reset; port 0 wins the first post-reset tie.
- Requester dropping `req` with no acceptance is legal; no access issued.

## Test plan
- Reset with both ports requesting: after reset release, `grant`=01 next cycle; `s1_ready` stays 0 until port 0 is released.
- Both ports stream reads (BURST_MAX=4, m_ready=1): grant alternates 01/10 every 4 acceptances; counts equal (4/4) over 8 accesses.
- Single port continuous, other idle: port 0 reissued grant after 4 beats with no IDLE cycle; 16 accesses in 16+1 cycles.
- READ_LATENCY=2: port 0 read addr 0x00010 at t, grant switches to port 1 at t+1 -> `s0_read_valid` at t+2 with `m_read_data`; `s1_read_valid` stays 0.
- Port 1 write 0xBEEF to 0x00020 with `m_ready` low 3 cycles: `m_req`/addr/data held, accepted on 4th cycle, no `read_valid`.
- Reset asserted one cycle after a read acceptance: no `read_valid` on either port afterwards; all outputs at reset values.
